// File: rtl/mips_regfile_write_arbiter_pkg.sv
// Purpose : shared types for the register-file write-port arbiter (register address,
//           data word, buffered long-latency result record) plus small helpers.
// Latency : n/a (types and pure functions only).
// Backpressure: n/a.
package mips_regfile_write_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int WORD_W     = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [WORD_W-1:0]     word_t;

  // One buffered long-latency result: destination register plus value.
  typedef struct packed {
    reg_addr_t addr;
    word_t     data;
  } aux_write_t;

  function automatic aux_write_t aux_pack(input reg_addr_t addr, input word_t data);
    aux_write_t w;
    w.addr = addr;
    w.data = data;
    return w;
  endfunction

  function automatic reg_addr_t aux_unpack_addr(input aux_write_t w);
    return w.addr;
  endfunction

  function automatic word_t aux_unpack_data(input aux_write_t w);
    return w.data;
  endfunction

  // One-hot register mask; register 0 is hard-wired zero so it never gets a bit.
  function automatic logic [31:0] reg_onehot(input reg_addr_t a);
    logic [31:0] m;
    m = '0;
    if (a != '0) m[a] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/mips_regfile_write_fifo.sv
// Purpose : small result FIFO holding long-latency writes until the register-file
//           port is free. Ports: clk/rst, push+push_data, pop, head, full, empty.
// Latency : a pushed entry is visible at head the cycle after the push edge.
// Backpressure: push is ignored while full, pop is ignored while empty.
module mips_regfile_write_fifo
  import mips_regfile_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  aux_write_t push_data,
  input  logic       pop,
  output aux_write_t head,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = $clog2(DEPTH);

  aux_write_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  // One bit wider than the pointers so that full and empty are distinguishable.
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage carries no reset: an entry is only observable once count covers it.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mips_regfile_write_arbiter.sv
// Purpose : owns the single register-file write port, sharing it between pipeline
//           writeback (always wins) and buffered long-latency results; keeps a pending
//           scoreboard and raises the ID hazard stall.
// Latency : pipeline writeback passes through combinationally; a long-latency result
//           pushed at edge N is written no earlier than cycle N+1.
// Backpressure: aux_ready drops when the FIFO is full; hold_pipe asks for a writeback
//           bubble once the FIFO head has waited STARVE_LIMIT cycles.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   wb_en, wb_addr, wb_data           pipeline writeback request
//   aux_issue, aux_issue_adr          long-latency op issued, its destination
//   aux_valid, aux_ready, aux_addr, aux_data   long-latency result handshake
//   id_rs, id_rt, id_dst, id_dst_en   register usage of the instruction in ID
//   haz_stall, hold_pipe              stall ID / request writeback bubble
//   wr_enable, wr_addr, wr_data       register-file write port
//   pend_mask                         pending-write scoreboard
module mips_regfile_write_arbiter
  import mips_regfile_write_arbiter_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        aux_issue,
  input  logic [4:0]  aux_issue_adr,
  input  logic        aux_valid,
  output logic        aux_ready,
  input  logic [4:0]  aux_addr,
  input  logic [31:0] aux_data,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_dst,
  input  logic        id_dst_en,
  output logic        haz_stall,
  output logic        hold_pipe,
  output logic        wr_enable,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic [31:0] pend_mask
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  aux_write_t          fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic [31:0]         pend_q;
  logic [31:0]         set_vec;
  logic [31:0]         clr_vec;
  logic [31:0]         live_mask;
  logic [STARVE_W-1:0] starve_cnt;

  // ---------------------------------------------------------------------------
  // Result FIFO
  // ---------------------------------------------------------------------------
  assign aux_ready = ~rst & ~fifo_full;
  assign push      = aux_valid & aux_ready;
  // The head drains only in cycles the pipeline leaves the port free.
  assign pop       = ~rst & ~wb_en & ~fifo_empty;

  mips_regfile_write_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (aux_pack(aux_addr, aux_data)),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // ---------------------------------------------------------------------------
  // Write-port mux
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_enable = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    if (!rst) begin
      if (wb_en) begin
        wr_enable = 1'b1;
        wr_addr   = wb_addr;
        wr_data   = wb_data;
      end else if (!fifo_empty) begin
        // A result aimed at r0 is still popped, just never written.
        wr_enable = (aux_unpack_addr(fifo_head) != '0);
        wr_addr   = aux_unpack_addr(fifo_head);
        wr_data   = aux_unpack_data(fifo_head);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pending scoreboard
  // ---------------------------------------------------------------------------
  assign set_vec = aux_issue ? reg_onehot(aux_issue_adr) : '0;
  assign clr_vec = pop ? reg_onehot(aux_unpack_addr(fifo_head)) : '0;

  // Clear first, then set, so a new issue to the register being retired survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= ((pend_q & ~clr_vec) | set_vec) & ~32'h1;
    end
  end

  assign pend_mask = pend_q;

  // An issue in this very cycle has not reached pend_q yet, so fold it in here.
  // Bit 0 is zero in both terms, so r0 never stalls.
  assign live_mask = pend_q | set_vec;
  assign haz_stall = ~rst & (live_mask[id_rs] | live_mask[id_rt] |
                             (id_dst_en & live_mask[id_dst]));

  // ---------------------------------------------------------------------------
  // Starvation counter: counts cycles the head is blocked by writeback.
  // Saturates at the limit so a very long writeback burst cannot wrap it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (pop || fifo_empty) begin
      starve_cnt <= '0;
    end else if (wb_en && (starve_cnt < STARVE_MAX)) begin
      starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end

  assign hold_pipe = ~rst & (starve_cnt >= STARVE_MAX);

  // The stall should keep the pipeline from ever writing a register that still has a
  // long-latency result in flight; if it does, the late result would clobber it.
  always_ff @(posedge clk) begin
    if (!rst && wb_en) begin
      assert (!pend_q[wb_addr]);
    end
  end

endmodule

// File: tb/tb_mips_regfile_write_arbiter.sv
module tb_mips_regfile_write_arbiter;

  logic        clk;
  logic        rst;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        aux_issue;
  logic [4:0]  aux_issue_adr;
  logic        aux_valid;
  logic        aux_ready;
  logic [4:0]  aux_addr;
  logic [31:0] aux_data;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_dst;
  logic        id_dst_en;
  logic        haz_stall;
  logic        hold_pipe;
  logic        wr_enable;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] pend_mask;

  int n_cmp = 0;
  int n_bad = 0;

  mips_regfile_write_arbiter #(
    .DEPTH        (4),
    .STARVE_LIMIT (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wb_en         (wb_en),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .aux_issue     (aux_issue),
    .aux_issue_adr (aux_issue_adr),
    .aux_valid     (aux_valid),
    .aux_ready     (aux_ready),
    .aux_addr      (aux_addr),
    .aux_data      (aux_data),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_dst        (id_dst),
    .id_dst_en     (id_dst_en),
    .haz_stall     (haz_stall),
    .hold_pipe     (hold_pipe),
    .wr_enable     (wr_enable),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .pend_mask     (pend_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1ns after a rising edge; checks happen 1-2ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h1111_2222;
    aux_valid = 1'b1; aux_addr = 5'd3; aux_data = 32'h3;
    aux_issue = 1'b1; aux_issue_adr = 5'd6; id_rs = 5'd6; id_rt = 5'd0; id_dst = 5'd0; id_dst_en = 1'b0;
    tick(); tick();
    n_cmp++; if (wr_enable !== 1'b0) begin n_bad++; $display("FAIL rst_wr_enable got=%b exp=0", wr_enable); end
    n_cmp++; if (aux_ready !== 1'b0) begin n_bad++; $display("FAIL rst_aux_ready got=%b exp=0", aux_ready); end
    n_cmp++; if (haz_stall !== 1'b0) begin n_bad++; $display("FAIL rst_haz_stall got=%b exp=0", haz_stall); end
    n_cmp++; if (hold_pipe !== 1'b0) begin n_bad++; $display("FAIL rst_hold_pipe got=%b exp=0", hold_pipe); end
    n_cmp++; if (pend_mask !== 32'h0) begin n_bad++; $display("FAIL rst_pend_mask got=%h exp=0", pend_mask); end
    rst = 1'b0; wb_en = 1'b0; aux_valid = 1'b0; aux_issue = 1'b0; id_rs = 5'd0;
    #1;
    n_cmp++; if (aux_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_aux_ready got=%b exp=1", aux_ready); end
    n_cmp++; if (wr_enable !== 1'b0) begin n_bad++; $display("FAIL post_rst_wr_enable got=%b exp=0", wr_enable); end
    n_cmp++; if (pend_mask !== 32'h0) begin n_bad++; $display("FAIL post_rst_pend got=%h exp=0", pend_mask); end
    tick();
  endtask

  task automatic test_issue_write_hazard();
    aux_issue = 1'b1; aux_issue_adr = 5'd5; id_rs = 5'd5; id_rt = 5'd0; #1;
    n_cmp++; if (haz_stall !== 1'b1) begin n_bad++; $display("FAIL haz_same_cycle got=%b exp=1", haz_stall); end
    tick();
    aux_issue = 1'b0; #1;
    n_cmp++; if (pend_mask !== 32'h0000_0020) begin n_bad++; $display("FAIL pend_set5 got=%h exp=00000020", pend_mask); end
    n_cmp++; if (haz_stall !== 1'b1) begin n_bad++; $display("FAIL haz_rs5 got=%b exp=1", haz_stall); end
    id_rs = 5'd0; id_rt = 5'd0; #1;
    n_cmp++; if (haz_stall !== 1'b0) begin n_bad++; $display("FAIL haz_rt0 got=%b exp=0", haz_stall); end
    id_dst = 5'd5; id_dst_en = 1'b1; tick();
    n_cmp++; if (haz_stall !== 1'b1) begin n_bad++; $display("FAIL haz_dst5 got=%b exp=1", haz_stall); end
    id_dst_en = 1'b0; tick();
    wb_en = 1'b0; aux_valid = 1'b1; aux_addr = 5'd5; aux_data = 32'hDEAD_BEEF; #1;
    n_cmp++; if (wr_enable !== 1'b0) begin n_bad++; $display("FAIL no_bypass got=%b exp=0", wr_enable); end
    tick();
    aux_valid = 1'b0; #1;
    n_cmp++; if (wr_enable !== 1'b1) begin n_bad++; $display("FAIL aux_wr_en got=%b exp=1", wr_enable); end
    n_cmp++; if (wr_addr !== 5'd5) begin n_bad++; $display("FAIL aux_wr_addr got=%0d exp=5", wr_addr); end
    n_cmp++; if (wr_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL aux_wr_data got=%h exp=deadbeef", wr_data); end
    n_cmp++; if (pend_mask !== 32'h0000_0020) begin n_bad++; $display("FAIL pend_before_pop got=%h exp=00000020", pend_mask); end
    tick();
    n_cmp++; if (pend_mask !== 32'h0) begin n_bad++; $display("FAIL pend_clr5 got=%h exp=0", pend_mask); end
    n_cmp++; if (wr_enable !== 1'b0) begin n_bad++; $display("FAIL idle_after_pop got=%b exp=0", wr_enable); end
  endtask

  task automatic test_zero_reg();
    aux_issue = 1'b1; aux_issue_adr = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    aux_valid = 1'b1; aux_addr = 5'd0; aux_data = 32'h55; #1;
    n_cmp++; if (haz_stall !== 1'b0) begin n_bad++; $display("FAIL haz_r0 got=%b exp=0", haz_stall); end
    tick();
    aux_issue = 1'b0; aux_addr = 5'd9; aux_data = 32'h99; #1;
    n_cmp++; if (pend_mask !== 32'h0) begin n_bad++; $display("FAIL pend_r0 got=%h exp=0", pend_mask); end
    n_cmp++; if (wr_enable !== 1'b0) begin n_bad++; $display("FAIL r0_discard got=%b exp=0", wr_enable); end
    tick();
    aux_valid = 1'b0; #1;
    n_cmp++; if (wr_enable !== 1'b1 || wr_addr !== 5'd9 || wr_data !== 32'h99) begin n_bad++; $display("FAIL after_r0 got=%b/%0d/%h exp=1/9/00000099", wr_enable, wr_addr, wr_data); end
    tick();
  endtask

  task automatic test_starvation();
    wb_en = 1'b1; wb_addr = 5'd10; wb_data = 32'hCAFE_0010;
    aux_valid = 1'b1; aux_addr = 5'd12; aux_data = 32'h1234;
    tick();
    aux_valid = 1'b0; #1;
    n_cmp++; if (wr_addr !== 5'd10 || wr_data !== 32'hCAFE_0010) begin n_bad++; $display("FAIL wb_wins got=%0d/%h exp=10/cafe0010", wr_addr, wr_data); end
    for (int i = 0; i < 7; i++) begin
      tick();
      n_cmp++; if (hold_pipe !== 1'b0) begin n_bad++; $display("FAIL hold_early cyc=%0d got=%b exp=0", i + 1, hold_pipe); end
    end
    tick();
    n_cmp++; if (hold_pipe !== 1'b1) begin n_bad++; $display("FAIL hold_at_limit got=%b exp=1", hold_pipe); end
    wb_en = 1'b0; #1;
    n_cmp++; if (wr_enable !== 1'b1 || wr_addr !== 5'd12 || wr_data !== 32'h1234) begin n_bad++; $display("FAIL starve_drain got=%b/%0d/%h exp=1/12/00001234", wr_enable, wr_addr, wr_data); end
    tick();
    n_cmp++; if (hold_pipe !== 1'b0) begin n_bad++; $display("FAIL hold_release got=%b exp=0", hold_pipe); end
    n_cmp++; if (wr_enable !== 1'b0) begin n_bad++; $display("FAIL starve_empty got=%b exp=0", wr_enable); end
  endtask

  task automatic test_full_back_to_back();
    logic [4:0]  ea;
    logic [31:0] ed;
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h33;
    for (int i = 0; i < 4; i++) begin
      aux_valid = 1'b1; aux_addr = 5'(20 + i); aux_data = 32'(32'hA0 + i); #1;
      n_cmp++; if (aux_ready !== 1'b1) begin n_bad++; $display("FAIL fill_ready i=%0d got=%b exp=1", i, aux_ready); end
      tick();
    end
    aux_addr = 5'd24; aux_data = 32'hBAD; #1;
    n_cmp++; if (aux_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready got=%b exp=0", aux_ready); end
    tick();
    aux_valid = 1'b0; wb_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ea = 5'(20 + i); ed = 32'(32'hA0 + i); #1;
      n_cmp++; if (wr_enable !== 1'b1 || wr_addr !== ea || wr_data !== ed) begin n_bad++; $display("FAIL drain i=%0d got=%b/%0d/%h exp=1/%0d/%h", i, wr_enable, wr_addr, wr_data, ea, ed); end
      tick();
    end
    n_cmp++; if (wr_enable !== 1'b0) begin n_bad++; $display("FAIL overflow_dropped got=%b/%0d exp=0", wr_enable, wr_addr); end
    n_cmp++; if (aux_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after_drain got=%b exp=1", aux_ready); end
  endtask

  task automatic test_set_wins_and_reset();
    wb_en = 1'b0; aux_valid = 1'b1; aux_addr = 5'd7; aux_data = 32'h77;
    aux_issue = 1'b1; aux_issue_adr = 5'd7;
    tick();
    aux_valid = 1'b0; #1;
    n_cmp++; if (pend_mask !== 32'h0000_0080 || wr_addr !== 5'd7) begin n_bad++; $display("FAIL pend7_head got=%h/%0d exp=00000080/7", pend_mask, wr_addr); end
    tick();
    aux_issue = 1'b0; #1;
    n_cmp++; if (pend_mask !== 32'h0000_0080) begin n_bad++; $display("FAIL set_wins got=%h exp=00000080", pend_mask); end
    n_cmp++; if (wr_enable !== 1'b0) begin n_bad++; $display("FAIL popped7 got=%b exp=0", wr_enable); end
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h9;
    aux_valid = 1'b1; aux_addr = 5'd25; aux_data = 32'h25; tick();
    aux_addr = 5'd26; aux_data = 32'h26; tick();
    aux_valid = 1'b0; rst = 1'b1; tick();
    n_cmp++; if (aux_ready !== 1'b0 || wr_enable !== 1'b0) begin n_bad++; $display("FAIL midrst got=%b/%b exp=0/0", aux_ready, wr_enable); end
    rst = 1'b0; wb_en = 1'b0; #1;
    n_cmp++; if (pend_mask !== 32'h0) begin n_bad++; $display("FAIL midrst_pend got=%h exp=0", pend_mask); end
    n_cmp++; if (aux_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready got=%b exp=1", aux_ready); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (wr_enable !== 1'b0) begin n_bad++; $display("FAIL midrst_flushed cyc=%0d got=%b/%0d exp=0", i, wr_enable, wr_addr); end
      tick();
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_issue_write_hazard();
    test_zero_reg();
    test_starvation();
    test_full_back_to_back();
    test_set_wins_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
